// File: rtl/serdiv_radix.sv
// Radix-2^BITS_PER_CYCLE restoring serial divider (udiv/div/urem/rem, RV64 word ops).
// Optional SERDIV_RADIX_FASTPATH_EN: divide-by-zero and signed overflow skip the iterations.
module serdiv_radix #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 2,
    parameter int TRANS_ID_BITS  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic                     word_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic                     flush_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o
);
    localparam int CW     = $clog2(WIDTH);
    localparam int N32_M1 = 32 / BITS_PER_CYCLE - 1;
    localparam int NW_M1  = WIDTH / BITS_PER_CYCLE - 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t                   state_reg, state_next;
    logic [CW-1:0]            cnt_reg;
    logic [WIDTH-1:0]         dvd_reg, dvs_reg, res_reg;
    logic [WIDTH:0]           rem_reg;
    logic [TRANS_ID_BITS-1:0] id_reg;
    logic                     rem_op_reg, q_neg_reg, r_neg_reg, word_reg;

    logic             load, iter, res_en;
    logic [WIDTH-1:0] res_next;

    // Operand conditioning at acceptance
    logic             word_eff, is_signed, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, dvd_load;
    logic [CW-1:0]    n_m1;

    always_comb begin
        word_eff  = (WIDTH == 64) && word_i;
        is_signed = opcode_i[0];
        if (word_eff) begin
            a_ext   = is_signed ? WIDTH'($signed(op_a_i[31:0])) : WIDTH'(op_a_i[31:0]);
            b_ext   = is_signed ? WIDTH'($signed(op_b_i[31:0])) : WIDTH'(op_b_i[31:0]);
            min_neg = WIDTH'($signed(32'h8000_0000));
            n_m1    = CW'(N32_M1);
        end else begin
            a_ext   = op_a_i;
            b_ext   = op_b_i;
            min_neg = {1'b1, {(WIDTH-1){1'b0}}};
            n_m1    = CW'(NW_M1);
        end
        a_neg    = is_signed & a_ext[WIDTH-1];
        b_neg    = is_signed & b_ext[WIDTH-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);
        // Word ops start with the 32-bit magnitude in the top half so MSB-first shifting works unchanged
        dvd_load = word_eff ? (a_mag << (WIDTH - 32)) : a_mag;
    end

    // BITS_PER_CYCLE restoring steps; quotient bits shift into the vacated low end of the dividend
    logic [WIDTH:0]   rem_it;
    logic [WIDTH-1:0] dvd_it, fin_val, fin_signed, fin_res;

    always_comb begin
        rem_it = rem_reg;
        dvd_it = dvd_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_it = {rem_it[WIDTH-1:0], dvd_it[WIDTH-1]};
            dvd_it = {dvd_it[WIDTH-2:0], 1'b0};
            if (rem_it >= {1'b0, dvs_reg}) begin
                rem_it    = rem_it - {1'b0, dvs_reg};
                dvd_it[0] = 1'b1;
            end
        end
        fin_val    = rem_op_reg ? rem_it[WIDTH-1:0] : dvd_it;
        fin_signed = (rem_op_reg ? r_neg_reg : q_neg_reg) ? -fin_val : fin_val;
        fin_res    = word_reg ? WIDTH'($signed(fin_signed[31:0])) : fin_signed;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        iter       = 1'b0;
        res_en     = 1'b0;
        res_next   = fin_res;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (in_vld_i) begin
                    load       = 1'b1;
                    state_next = DIVIDE;
`ifdef SERDIV_RADIX_FASTPATH_EN
                    if (div_zero || ovf) begin
                        state_next = FINISH;
                        res_en     = 1'b1;
                        if (opcode_i[1])
                            res_next = div_zero ? (word_eff ? WIDTH'($signed(op_a_i[31:0])) : op_a_i) : '0;
                        else
                            res_next = div_zero ? '1 : min_neg;
                    end
`endif
                end
                DIVIDE: begin
                    iter = 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = FINISH;
                        res_en     = 1'b1;
                    end
                end
                FINISH: if (out_rdy_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            res_reg    <= '0;
            id_reg     <= '0;
            rem_op_reg <= 1'b0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            word_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                cnt_reg    <= n_m1;
                dvd_reg    <= dvd_load;
                dvs_reg    <= b_mag;
                rem_reg    <= '0;
                id_reg     <= id_i;
                rem_op_reg <= opcode_i[1];
                // Divide-by-zero keeps the all-ones quotient unsigned-looking regardless of signs
                q_neg_reg  <= (a_neg ^ b_neg) & ~div_zero;
                r_neg_reg  <= a_neg;
                word_reg   <= word_eff;
            end
            if (iter) begin
                cnt_reg <= cnt_reg - 1'b1;
                dvd_reg <= dvd_it;
                rem_reg <= rem_it;
            end
            if (res_en) res_reg <= res_next;
        end
    end

    assign in_rdy_o  = (state_reg == IDLE) && !flush_i;
    assign out_vld_o = (state_reg == FINISH) && !flush_i;
    assign res_o     = res_reg;
    assign id_o      = id_reg;

endmodule

// File: tb/tb_serdiv_radix.sv
// Directed self-checking bench for serdiv_radix (WIDTH=64, BITS_PER_CYCLE=2).
// Fast-path latency expectations follow SERDIV_RADIX_FASTPATH_EN when defined.
module tb_serdiv_radix;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  id_in;
    logic [63:0] op_a, op_b;
    logic [1:0]  opcode;
    logic        word;
    logic        in_vld, in_rdy, flush, out_vld, out_rdy;
    logic [2:0]  id_out;
    logic [63:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int L64 = 33;
    localparam int L32 = 17;
`ifdef SERDIV_RADIX_FASTPATH_EN
    localparam int LFAST64 = 1;
    localparam int LFAST32 = 1;
`else
    localparam int LFAST64 = L64;
    localparam int LFAST32 = L32;
`endif

    always #5 clk = ~clk;

    serdiv_radix #(.WIDTH(64), .BITS_PER_CYCLE(2), .TRANS_ID_BITS(3)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .id_i     (id_in),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .opcode_i (opcode),
        .word_i   (word),
        .in_vld_i (in_vld),
        .in_rdy_o (in_rdy),
        .flush_i  (flush),
        .out_vld_o(out_vld),
        .out_rdy_i(out_rdy),
        .id_o     (id_out),
        .res_o    (res)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, obs);
        end
    endtask

    // Issue one request and wait (bounded) for its result; handshake when out_rdy is high.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic w, input logic [2:0] id,
                         input logic [63:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; opcode = op; word = w; id_in = id; in_vld = 1'b1;
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1 in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, res, exp_res);
        check({tag, "_id"}, 64'(id_out), 64'(id));
        if (out_rdy) begin
            @(posedge clk);
            #1 check({tag, "_done_vld"}, 64'(out_vld), 64'd0);
            check({tag, "_done_rdy"}, 64'(in_rdy), 64'd1);
        end
    endtask

    // Watch for a spurious result over a fixed window.
    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 if (out_vld) seen = 1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] held_res;
        logic [2:0]  held_id;
        rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        op_a = '0; op_b = '0; opcode = 2'd0; word = 1'b0; id_in = '0;
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_id", 64'(id_out), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_in_rdy", 64'(in_rdy), 64'd1);

        do_op("udiv_100_7", 64'd100, 64'd7, 2'd0, 1'b0, 3'd5, 64'd14, L64);
        do_op("rem_m100_7", -64'sd100, 64'd7, 2'd3, 1'b0, 3'd1, -64'sd2, L64);
        do_op("div_100_m7", 64'd100, -64'sd7, 2'd1, 1'b0, 3'd2, -64'sd14, L64);
        do_op("urem_100_7", 64'd100, 64'd7, 2'd2, 1'b0, 3'd3, 64'd2, L64);
        do_op("udiv_max_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd0, 1'b0, 3'd4,
              64'h7FFF_FFFF_FFFF_FFFF, L64);
        do_op("div_m5_0", -64'sd5, 64'd0, 2'd1, 1'b0, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, LFAST64);
        do_op("rem_m5_0", -64'sd5, 64'd0, 2'd3, 1'b0, 3'd7, -64'sd5, LFAST64);
        do_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 3'd0,
              64'h8000_0000_0000_0000, LFAST64);
        do_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b0, 3'd1,
              64'd0, LFAST64);
        do_op("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 3'd2,
              64'hFFFF_FFFF_8000_0000, LFAST32);
        do_op("divuw", 64'h0000_0000_FFFF_FFFE, 64'd1, 2'd0, 1'b1, 3'd3,
              64'hFFFF_FFFF_FFFF_FFFE, L32);
        do_op("remw_m7_2", 64'h1234_5678_FFFF_FFF9, 64'd2, 2'd3, 1'b1, 3'd4,
              64'hFFFF_FFFF_FFFF_FFFF, L32);

        // Flush on the 10th DIVIDE cycle
        @(negedge clk);
        op_a = 64'd100; op_b = 64'd7; opcode = 2'd0; word = 1'b0; id_in = 3'd5; in_vld = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        #1 check("flush_comb_rdy", 64'(in_rdy), 64'd0);
        check("flush_comb_vld", 64'(out_vld), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        #1 check("flush_next_rdy", 64'(in_rdy), 64'd1);
        expect_quiet("flush_no_result", 40);
        do_op("udiv_9_3", 64'd9, 64'd3, 2'd0, 1'b0, 3'd6, 64'd3, L64);

        // Flush beats a simultaneous request
        @(negedge clk);
        op_a = 64'd50; op_b = 64'd5; opcode = 2'd0; id_in = 3'd1; in_vld = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0; flush = 1'b0;
        #1 check("flush_prio_rdy", 64'(in_rdy), 64'd1);
        expect_quiet("flush_prio_quiet", 40);

        // Backpressure holds the result
        out_rdy = 1'b0;
        do_op("hold", 64'd1000, 64'd10, 2'd0, 1'b0, 3'd7, 64'd100, L64);
        held_res = res; held_id = id_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_res_%0d", i), res, held_res);
            check($sformatf("hold_id_%0d", i), 64'(id_out), 64'(held_id));
            check($sformatf("hold_rdy_%0d", i), 64'(in_rdy), 64'd0);
            check($sformatf("hold_vld_%0d", i), 64'(out_vld), 64'd1);
        end
        @(negedge clk) out_rdy = 1'b1;
        @(posedge clk);
        #1 check("hold_release_vld", 64'(out_vld), 64'd0);
        check("hold_release_rdy", 64'(in_rdy), 64'd1);

        // Reset mid-operation abandons the division
        @(negedge clk);
        op_a = 64'd77; op_b = 64'd7; opcode = 2'd0; id_in = 3'd3; in_vld = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("midrst_vld", 64'(out_vld), 64'd0);
        check("midrst_res", res, 64'd0);
        check("midrst_id", 64'(id_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("midrst_rdy", 64'(in_rdy), 64'd1);
        expect_quiet("midrst_quiet", 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serdiv_radix.md
SERDIV_RADIX -- requirements
Module: serdiv_radix

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; legal values are 32 and 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, quotient bits per iteration; legal values are 1, 2 and 4.
REQ-003 SHALL have port clk_i  in  1  clock.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_i  in  TRANS_ID_BITS  transaction id (ariane_pkg).
REQ-006 SHALL have port op_a_i  in  WIDTH  dividend.
REQ-007 SHALL have port op_b_i  in  WIDTH  divisor.
REQ-008 SHALL have port opcode_i  in  2  operation: 0 udiv, 1 div, 2 urem, 3 rem.
REQ-009 SHALL have port word_i  in  1  32-bit word op (DIVW family); ignored when WIDTH=32.
REQ-010 SHALL have port in_vld_i  in  1  request valid.
REQ-011 SHALL have port in_rdy_o  out  1  request ready.
REQ-012 SHALL have port flush_i  in  1  abort.
REQ-013 SHALL have port out_vld_o  out  1  result valid.
REQ-014 SHALL have port out_rdy_i  in  1  result ready.
REQ-015 SHALL have port id_o  out  TRANS_ID_BITS  id of the result.
REQ-016 SHALL have port res_o  out  WIDTH  quotient or remainder.

Function
REQ-017 SHALL implement FSM IDLE -> DIVIDE -> FINISH -> IDLE.
REQ-018 SHALL drive in_rdy_o = (state==IDLE) & ~flush_i; a request is accepted only when in_vld_i & in_rdy_o.
REQ-019 SHALL, on acceptance, latch operands, opcode, word_i and id_i, and enter DIVIDE.
REQ-020 SHALL run exactly N = EW/BITS_PER_CYCLE cycles in DIVIDE, where EW = 32 if word_i, else WIDTH; the iteration counter is loaded with N-1 on acceptance.
REQ-021 SHALL retire BITS_PER_CYCLE quotient bits per DIVIDE cycle (restoring, MSB first), operating on operand magnitudes.
REQ-022 SHALL enter FINISH when the counter is 0, and assert out_vld_o in FINISH only; first out_vld_o comes N+1 cycles after the acceptance edge.
REQ-023 SHALL hold res_o and id_o stable while out_vld_o & ~out_rdy_i; on out_vld_o & out_rdy_i, return to IDLE the next cycle.
REQ-024 SHALL apply signed opcodes: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-025 SHALL, for word_i, use only op bits [31:0] (sign- or zero-extended per opcode) and sign-extend the 32-bit result from bit 31 to WIDTH, for all four opcodes.
REQ-026 SHALL, on divisor zero, return quotient all-ones and remainder equal to the dividend (truncated and sign-extended in word mode).
REQ-027 SHALL, on signed overflow (most-negative / -1 in EW bits), return quotient equal to the most-negative value and remainder 0.
REQ-028 SHALL, on flush_i in any state, force IDLE the next cycle, deassert out_vld_o and in_rdy_o combinationally that cycle, and discard any pending result.
REQ-029 SHALL give flush_i priority over a simultaneous in_vld_i; such a request is not accepted.

Reset
REQ-030 SHALL, in reset, set state IDLE, out_vld_o 0, id_o 0, res_o 0, and clear all datapath registers; in_rdy_o is 1 after reset when flush_i is 0.
REQ-031 SHALL, on reset asserted mid-operation, abandon the division with no result.

Configuration
REQ-032 SHALL, with SERDIV_RADIX_FASTPATH_EN defined, go from acceptance directly to FINISH for divisor-zero and signed-overflow requests (out_vld_o 1 cycle after acceptance, results per REQ-026/027).
REQ-033 SHALL, without SERDIV_RADIX_FASTPATH_EN, take the full N cycles for all requests, with identical results.

Verification (WIDTH=64, BITS_PER_CYCLE=2, macro undefined unless stated)
REQ-034 udiv 100/7, id 5 -> out_vld_o on cycle 33 after acceptance, res_o=14, id_o=5; rem -100/7 -> res_o=-2.
REQ-035 div -5/0 -> res_o=0xFFFF_FFFF_FFFF_FFFF; rem -5/0 -> res_o=-5; div 0x8000_0000_0000_0000/-1 -> res_o=0x8000_0000_0000_0000; rem of the same -> 0.
REQ-036 word_i=1 div 0x0000_0000_8000_0000/0xFFFF_FFFF_FFFF_FFFF -> res_o=0xFFFF_FFFF_8000_0000 after 17 cycles; divuw 0xFFFF_FFFE/1 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-037 flush_i on cycle 10 of DIVIDE -> no out_vld_o, in_rdy_o=1 next cycle; a subsequent udiv 9/3 -> 3.
REQ-038 out_rdy_i held 0 for 5 cycles in FINISH -> res_o and id_o constant and in_rdy_o=0 throughout; out_rdy_i=1 -> IDLE next cycle.
REQ-039 macro defined: div 7/0 -> out_vld_o 1 cycle after acceptance, res_o all-ones; udiv 100/7 still takes 33 cycles.
